// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: registered result, zero and overflow flags.
// Serial 1-bit/cycle shifter unless FAST_SHIFT; valid/ready on both sides.
//
// Ports:
//   clk, reset            rising-edge clock, async active-high reset
//   in_valid/in_ready     operation handshake (alu_cnt, op_a, op_b, shamt)
//   out_valid/out_ready   result handshake (result, zero, overflow)
module alu_exec_unit #(
  parameter int DATA_W     = 32,
  parameter int SHAMT_W    = 5,
  parameter bit FAST_SHIFT = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         alu_cnt,
  input  logic [DATA_W-1:0]  op_a,
  input  logic [DATA_W-1:0]  op_b,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  result,
  output logic               zero,
  output logic               overflow
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t              state_q;
  logic [DATA_W-1:0]   acc_q;
  logic [SHAMT_W-1:0]  cnt_q;
  logic                left_q;
  logic [DATA_W-1:0]   result_q;
  logic                zero_q;
  logic                ovf_q;

  logic [DATA_W-1:0]   res_d;
  logic                ovf_d;
  logic [DATA_W-1:0]   sum;
  logic [DATA_W-1:0]   diff;
  logic [DATA_W-1:0]   acc_step;
  logic                accept;
  logic                is_shift;
  logic                go_serial;

  assign in_ready  = (state_q == IDLE) ||
                     ((state_q == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign zero      = zero_q;
  assign overflow  = ovf_q;

  assign sum  = op_a + op_b;
  assign diff = op_a - op_b;

  assign is_shift  = (alu_cnt == 4'b1000) ||
                     (alu_cnt == 4'b1001);
  assign go_serial = is_shift && !FAST_SHIFT &&
                     (shamt != '0);

  assign acc_step = left_q ? (acc_q << 1) : (acc_q >> 1);

  always_comb begin
    res_d = '0;
    ovf_d = 1'b0;
    unique case (alu_cnt)
      4'b0000: begin
        res_d = sum;
        ovf_d = (op_a[DATA_W-1] == op_b[DATA_W-1]) &&
                (sum[DATA_W-1] != op_a[DATA_W-1]);
      end
      4'b0001: begin
        res_d = diff;
        ovf_d = (op_a[DATA_W-1] != op_b[DATA_W-1]) &&
                (diff[DATA_W-1] != op_a[DATA_W-1]);
      end
      4'b0010: res_d = op_a & op_b;
      4'b0011: res_d = op_a | op_b;
      4'b0100: res_d = op_a ^ op_b;
      4'b0101: res_d = ~(op_a | op_b);
      4'b0110: res_d = {{(DATA_W-1){1'b0}},
                        $signed(op_a) < $signed(op_b)};
      4'b0111: res_d = {{(DATA_W-1){1'b0}}, op_a < op_b};
      4'b1000: res_d = op_b >> shamt;
      4'b1001: res_d = op_b << shamt;
      default: res_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      cnt_q    <= '0;
      left_q   <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      unique case (state_q)
        SHIFT: begin
          acc_q <= acc_step;
          cnt_q <= cnt_q - 1'b1;
          // last step lands directly in result
          if (cnt_q == SHAMT_W'(1)) begin
            result_q <= acc_step;
            zero_q   <= (acc_step == '0);
            ovf_q    <= 1'b0;
            state_q  <= DONE;
          end
        end
        default: begin
          if (accept) begin
            if (go_serial) begin
              acc_q   <= op_b;
              cnt_q   <= shamt;
              left_q  <= alu_cnt[0];
              state_q <= SHIFT;
            end else begin
              result_q <= res_d;
              zero_q   <= (res_d == '0);
              ovf_q    <= ovf_d;
              state_q  <= DONE;
            end
          end else if ((state_q == DONE) && out_ready) begin
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed vectors, scoreboard queue
// filled at accept, drained by an independent output monitor.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_cnt;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [4:0]  shamt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        overflow;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] r;
    logic        z;
    logic        ov;
  } exp_t;

  exp_t sb[$];

  alu_exec_unit dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_cnt(alu_cnt), .op_a(op_a), .op_b(op_b),
    .shamt(shamt),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // monitor: one transfer per negedge with out_valid & out_ready
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", 32'h1, 32'h0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", result, e.r);
        chk("zero", {31'b0, zero}, {31'b0, e.z});
        chk("overflow", {31'b0, overflow}, {31'b0, e.ov});
      end
    end
  end

  task automatic issue(input logic [3:0]  op,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [4:0]  sh,
                       input bit          push,
                       input logic [31:0] er,
                       input logic        ez,
                       input logic        eo);
    bit rdy;
    int guard;
    exp_t e;
    alu_cnt  = op;
    op_a     = a;
    op_b     = b;
    shamt    = sh;
    in_valid = 1'b1;
    rdy      = 1'b0;
    guard    = 0;
    while (!rdy) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      guard++;
      if (guard > 200) begin
        chk("accept_timeout", 32'h1, 32'h0);
        break;
      end
    end
    if (push) begin
      e.r  = er;
      e.z  = ez;
      e.ov = eo;
      sb.push_back(e);
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
    alu_cnt  = 4'h0;
    op_a     = 32'h0;
    op_b     = 32'h0;
    shamt    = 5'h0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r0;
    logic        z0, o0;
    bit          stable;
    bit          rdy_seen;
    int          cyc;

    reset     = 1'b1;
    out_ready = 1'b1;
    idle();
    tick(3);
    chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_result", result, 32'h0);
    chk("rst_zero", {31'b0, zero}, 32'h1);
    chk("rst_overflow", {31'b0, overflow}, 32'h0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'h1);
    @(negedge clk);
    reset = 1'b0;
    tick(1);

    // add overflow, 1-cycle latency
    issue(4'b0000, 32'h7FFF_FFFF, 32'h1, 5'd0,
          1, 32'h8000_0000, 1'b0, 1'b1);
    chk("add_latency", {31'b0, out_valid}, 32'h1);
    idle();
    tick(1);

    // beq compare, slt, sltu
    issue(4'b0001, 32'd5, 32'd5, 5'd0, 1, 32'h0, 1'b1, 1'b0);
    issue(4'b0110, 32'hFFFF_FFFF, 32'h1, 5'd0,
          1, 32'h1, 1'b0, 1'b0);
    issue(4'b0111, 32'hFFFF_FFFF, 32'h1, 5'd0,
          1, 32'h0, 1'b1, 1'b0);
    issue(4'b0001, 32'h8000_0000, 32'h1, 5'd0,
          1, 32'h7FFF_FFFF, 1'b0, 1'b1);
    issue(4'b0000, 32'hFFFF_FFFF, 32'h1, 5'd0,
          1, 32'h0, 1'b1, 1'b0);
    issue(4'b1010, 32'h1234_5678, 32'h9ABC_DEF0, 5'd3,
          1, 32'h0, 1'b1, 1'b0);
    idle();
    tick(2);

    // serial sll by 31; op_b changes after accept must not matter
    issue(4'b1001, 32'h0, 32'h1, 5'd31,
          1, 32'h8000_0000, 1'b0, 1'b0);
    in_valid = 1'b0;
    op_b     = 32'hFFFF_FFFF;
    shamt    = 5'd2;
    cyc      = 1;
    rdy_seen = 1'b0;
    while (!out_valid && cyc < 100) begin
      if (in_ready) rdy_seen = 1'b1;
      tick(1);
      cyc++;
    end
    chk("sll31_cycles", cyc, 32);
    chk("sll31_in_ready_low", {31'b0, rdy_seen}, 32'h0);
    idle();
    tick(1);

    // srl shamt 0 is single-cycle; serial srl by 4
    issue(4'b1000, 32'h0, 32'hABCD_1234, 5'd0,
          1, 32'hABCD_1234, 1'b0, 1'b0);
    chk("srl0_latency", {31'b0, out_valid}, 32'h1);
    issue(4'b1000, 32'h0, 32'h8000_0000, 5'd4,
          1, 32'h0800_0000, 1'b0, 1'b0);
    idle();
    tick(8);

    // backpressure: hold DONE for 4 cycles
    out_ready = 1'b0;
    issue(4'b0100, 32'hF0F0_0000, 32'h0F0F_1111, 5'd0,
          1, 32'hFFFF_1111, 1'b0, 1'b0);
    idle();
    r0     = result;
    z0     = zero;
    o0     = overflow;
    stable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (result !== r0 || zero !== z0 || overflow !== o0 ||
          in_ready !== 1'b0 || out_valid !== 1'b1)
        stable = 1'b0;
    end
    chk("bp_stable", {31'b0, stable}, 32'h1);
    chk("bp_held_result", r0, 32'hFFFF_1111);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    issue(4'b0011, 32'h1200_0000, 32'h0034_0000, 5'd0,
          1, 32'h1234_0000, 1'b0, 1'b0);
    chk("bp_handoff_valid", {31'b0, out_valid}, 32'h1);
    chk("bp_handoff_result", result, 32'h1234_0000);
    idle();
    tick(2);

    // streaming logic ops, one per cycle
    cyc = 0;
    issue(4'b0010, 32'hFFFF_0000, 32'h0F0F_0F0F, 5'd0,
          1, 32'h0F0F_0000, 1'b0, 1'b0);
    if (out_valid) cyc++;
    issue(4'b0011, 32'h1234_0000, 32'h0000_5678, 5'd0,
          1, 32'h1234_5678, 1'b0, 1'b0);
    if (out_valid) cyc++;
    issue(4'b0100, 32'hAAAA_AAAA, 32'h5555_5555, 5'd0,
          1, 32'hFFFF_FFFF, 1'b0, 1'b0);
    if (out_valid) cyc++;
    issue(4'b0101, 32'h0, 32'h0, 5'd0,
          1, 32'hFFFF_FFFF, 1'b0, 1'b0);
    if (out_valid) cyc++;
    issue(4'b0010, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 5'd0,
          1, 32'h0, 1'b1, 1'b0);
    if (out_valid) cyc++;
    issue(4'b0011, 32'h0, 32'h0, 5'd0,
          1, 32'h0, 1'b1, 1'b0);
    if (out_valid) cyc++;
    issue(4'b0100, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 5'd0,
          1, 32'h0, 1'b1, 1'b0);
    if (out_valid) cyc++;
    issue(4'b0101, 32'hFFFF_FFFF, 32'h0, 5'd0,
          1, 32'h0, 1'b1, 1'b0);
    if (out_valid) cyc++;
    chk("stream_valid_count", cyc, 8);
    idle();
    tick(3);

    // reset in the middle of a shift
    issue(4'b1001, 32'h0, 32'h0000_0003, 5'd20,
          0, 32'h0, 1'b0, 1'b0);
    idle();
    tick(3);
    reset = 1'b1;
    #1;
    chk("midrst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("midrst_result", result, 32'h0);
    chk("midrst_zero", {31'b0, zero}, 32'h1);
    @(negedge clk);
    reset = 1'b0;
    tick(1);
    issue(4'b0000, 32'd100, 32'd23, 5'd0,
          1, 32'd123, 1'b0, 1'b0);
    chk("post_rst_latency", {31'b0, out_valid}, 32'h1);
    idle();
    tick(40);
    chk("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
